// File: rtl/ka_pkg.sv
// Shared types and helpers for the Karatsuba overlap accumulator.
package ka_pkg;

   // Partial-product identifiers; encoding 3 is reserved and always rejected.
   typedef enum logic [1:0] {
      TERM_LO  = 2'd0,
      TERM_MID = 2'd1,
      TERM_HI  = 2'd2
   } term_tag_e;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_e;

   // Full product width: high term lands at 2*SHIFT and is PW bits wide.
   function automatic int ka_out_width(input int pw, input int shift);
      return pw + 2 * shift;
   endfunction

endpackage

// File: rtl/ka_shift_xor.sv
// Combinational next-accumulator: XORs one term in at its Karatsuba offset.
// With KA_MID_FOLD_EN defined, low and high terms are also folded in at
// offset SHIFT so a raw (a0+a1)(b0+b1) middle term gets corrected here.
module ka_shift_xor
   import ka_pkg::*;
#(
   parameter int PW    = 71,
   parameter int SHIFT = 36,
   parameter int OW    = ka_out_width(PW, SHIFT)
) (
   input  logic [OW-1:0] acc,
   input  logic [PW-1:0] data,
   input  logic [1:0]    tag,
   output logic [OW-1:0] acc_nxt
);

   logic [OW-1:0] ext;
   logic [OW-1:0] fold;

   // Zero-extend the term and place it at the offset selected by its tag.
   always_comb begin
      ext        = '0;
      ext[PW-1:0] = data;
`ifdef KA_MID_FOLD_EN
      fold = ext << SHIFT;
`else
      fold = '0;
`endif
      acc_nxt = acc;
      case (term_tag_e'(tag))
         TERM_LO:  acc_nxt = acc ^ ext ^ fold;
         TERM_MID: acc_nxt = acc ^ (ext << SHIFT);
         TERM_HI:  acc_nxt = acc ^ (ext << (2 * SHIFT)) ^ fold;
         default:  acc_nxt = acc;
      endcase
   end

endmodule

// File: rtl/overlap_accum_unit.sv
// Sequential Karatsuba overlap combiner: collects low/middle/high partial
// products in any order, XOR-accumulates them, then holds the full GF(2)
// product on a valid/ready output. Optional middle-term folding is enabled
// by defining KA_MID_FOLD_EN (see ka_shift_xor).
module overlap_accum_unit
   import ka_pkg::*;
#(
   parameter  int PW    = 71,
   parameter  int SHIFT = 36,
   localparam int OW    = ka_out_width(PW, SHIFT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_tag,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          err
);

   if (SHIFT < 1 || SHIFT > PW) begin : g_bad_shift
      $error("overlap_accum_unit: SHIFT must satisfy 1 <= SHIFT <= PW");
   end

   state_e        state;
   logic [OW-1:0] acc;
   logic [OW-1:0] acc_nxt;
   logic [2:0]    seen;
   logic [2:0]    seen_nxt;
   logic [3:0]    seen_ext;
   logic [3:0]    tag_hot;
   logic          accept;
   logic          fresh;

   ka_shift_xor #(.PW(PW), .SHIFT(SHIFT), .OW(OW)) u_shift_xor (
      .acc     (acc),
      .data    (in_data),
      .tag     (in_tag),
      .acc_nxt (acc_nxt)
   );

   // Tag 3 reads as permanently "seen", so illegal and duplicate terms share one reject path.
   always_comb begin
      in_ready = (state == ST_COLLECT) && !clear;
      accept   = in_valid && in_ready;
      seen_ext = {1'b1, seen};
      tag_hot  = 4'b0001 << in_tag;
      fresh    = !seen_ext[in_tag];
      seen_nxt = seen | tag_hot[2:0];
   end

   assign out_data = acc;

   // Frame control: accumulate fresh terms, flag rejects, hold and release the product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_COLLECT;
         acc       <= '0;
         seen      <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (clear) begin
            state     <= ST_COLLECT;
            acc       <= '0;
            seen      <= '0;
            out_valid <= 1'b0;
         end else begin
            case (state)
               ST_COLLECT: begin
                  if (accept) begin
                     if (fresh) begin
                        acc  <= acc_nxt;
                        seen <= seen_nxt;
                        if (seen_nxt == 3'b111) begin
                           state     <= ST_HOLD;
                           out_valid <= 1'b1;
                        end
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               ST_HOLD: begin
                  if (out_ready) begin
                     state     <= ST_COLLECT;
                     acc       <= '0;
                     seen      <= '0;
                     out_valid <= 1'b0;
                  end
               end
               default: state <= ST_COLLECT;
            endcase
         end
      end
   end

endmodule
